// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared types and constants for the seven-segment display arbiter.
//   state_e        : arbiter FSM states (IDLE, HOLD)
//   DIGIT_W        : bits per hex digit
//   NUM_DIGITS     : digits on the display
//   VALUE_W        : width of one packed requester value
//   *_LSB          : bit position of each digit inside a packed value
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int VALUE_W    = DIGIT_W * NUM_DIGITS;

    localparam int ONES_LSB      = 0;
    localparam int TENS_LSB      = 4;
    localparam int HUNDREDS_LSB  = 8;
    localparam int THOUSANDS_LSB = 12;

endpackage

// File: rtl/seg_scan_div.sv
// ---------------------------------------------------------------------------
// seg_scan_div
// Free-running divider that paces the display multiplexing.
//   clk, rst_n (async, active-low)
//   scan_tick : one-cycle strobe every SCAN_DIV cycles (constant 1 if SCAN_DIV=1)
//   digit_sel : active digit index, advances the cycle after each scan_tick
// ---------------------------------------------------------------------------
module seg_scan_div #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       scan_tick,
    output logic [1:0] digit_sel
);

    localparam int             CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic [1:0]    sel_q, sel_d;

    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        // Tick is registered, so it is decoded from the count being loaded;
        // the strobe then lines up with the cycle in which cnt_q == CNT_LAST.
        tick_d = (cnt_d == CNT_LAST);
        sel_d  = tick_q ? sel_q + 2'd1 : sel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sel_q  <= 2'd0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sel_q  <= sel_d;
        end
    end

    assign scan_tick = tick_q;
    assign digit_sel = sel_q;

endmodule

// File: rtl/seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter
// Round-robin arbiter sharing a 4-digit seven-segment display among NUM_REQ
// requesters. A granted value is held on screen for HOLD_CYCLES cycles; one
// IDLE cycle always separates consecutive grants. Also hosts the scan divider.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/req_value: per-requester offer; value i at [16i+15:16i]
//   req_ready          : one-cycle acceptance pulse per requester
//   ones..thousands    : registered digits to the display driver
//   owner, busy        : displayed requester index, high while in HOLD
//   scan_tick/digit_sel: divided scan strobe and active digit
// Optional build macro SEG_PRIO0_EN: requester 0 may preempt another owner
// during HOLD. Undefined: req_valid is ignored in HOLD.
// ---------------------------------------------------------------------------
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int SCAN_DIV    = 100_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [VALUE_W*NUM_REQ-1:0]   req_value,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DIGIT_W-1:0]           ones,
    output logic [DIGIT_W-1:0]           tens,
    output logic [DIGIT_W-1:0]           hundreds,
    output logic [DIGIT_W-1:0]           thousands,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         busy,
    output logic                         scan_tick,
    output logic [1:0]                   digit_sel
);

    localparam int            OW        = $clog2(NUM_REQ);
    localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_e               state_q, state_d;
    logic [OW-1:0]        ptr_q, ptr_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [VALUE_W-1:0]   disp_q, disp_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic                 busy_q, busy_d;

    logic                 grant_found;
    logic [OW-1:0]        grant_idx;
    int                   rr_idx;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = int'(ptr_q) + k;
            if (rr_idx >= NUM_REQ) begin
                rr_idx = rr_idx - NUM_REQ;
            end
            if (!grant_found && req_valid[rr_idx]) begin
                grant_found = 1'b1;
                grant_idx   = OW'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        disp_d  = disp_q;
        ready_d = '0;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    disp_d             = req_value[VALUE_W*int'(grant_idx) +: VALUE_W];
                    owner_d            = grant_idx;
                    ready_d[grant_idx] = 1'b1;
                    ptr_d              = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                    hold_d             = '0;
                    state_d            = HOLD;
                    busy_d             = 1'b1;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`ifdef SEG_PRIO0_EN
                // Preemption overrides hold expiry and restarts a full hold.
                if (req_valid[0] && (owner_q != '0)) begin
                    disp_d     = req_value[VALUE_W-1:0];
                    owner_d    = '0;
                    ready_d[0] = 1'b1;
                    ptr_d      = OW'(1);
                    hold_d     = '0;
                    state_d    = HOLD;
                    busy_d     = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            hold_q  <= '0;
            disp_q  <= '0;
            ready_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            disp_q  <= disp_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ready = ready_q;
    assign owner     = owner_q;
    assign busy      = busy_q;
    assign ones      = disp_q[ONES_LSB      +: DIGIT_W];
    assign tens      = disp_q[TENS_LSB      +: DIGIT_W];
    assign hundreds  = disp_q[HUNDREDS_LSB  +: DIGIT_W];
    assign thousands = disp_q[THOUSANDS_LSB +: DIGIT_W];

    seg_scan_div #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_tick (scan_tick),
        .digit_sel (digit_sel)
    );

endmodule

// File: tb/tb_seg_display_arbiter.sv
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_value = '0;
    logic [3:0]  req_ready;
    logic [3:0]  ones, tens, hundreds, thousands;
    logic [1:0]  owner;
    logic        busy;
    logic        scan_tick;
    logic [1:0]  digit_sel;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    seg_display_arbiter #(
        .NUM_REQ     (4),
        .HOLD_CYCLES (8),
        .SCAN_DIV    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_value (req_value),
        .req_ready (req_ready),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .owner     (owner),
        .busy      (busy),
        .scan_tick (scan_tick),
        .digit_sel (digit_sel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_val(input int i, input logic [15:0] v);
        req_value[16*i +: 16] = v;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] digits();
        return {thousands, hundreds, tens, ones};
    endfunction

    logic [3:0]  fair_valid;
    int          exp_order[5];
    int          last_cyc;
    int          gcyc;
    bit          got;
    logic [15:0] v;

    initial begin
        // ---------------- 1. reset and scan divider ----------------
        step();
        step();
        check("rst_digits", 32'(digits()), 32'h0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_tick", 32'(scan_tick), 32'd0);
        check("rst_sel", 32'(digit_sel), 32'd0);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("scan_tick", 32'(scan_tick), (i % 4 == 3) ? 32'd1 : 32'd0);
            check("digit_sel", 32'(digit_sel), 32'((i / 4) % 4));
        end
        $display("scan: 12 cycles stepped, sel=%0d", digit_sel);

        // ---------------- 2. single grant ----------------
        set_val(2, 16'h1234);
        req_valid = 4'b0100;
        step();
        $display("grant: owner=%0d value=%h ready=%b", owner, digits(), req_ready);
        check("single_ready", 32'(req_ready), 32'b0100);
        check("single_digits", 32'(digits()), 32'h1234);
        check("single_owner", 32'(owner), 32'd2);
        check("single_busy", 32'(busy), 32'd1);
        req_valid = '0;
        for (int j = 2; j <= 8; j++) begin
            step();
            check("single_busy_hold", 32'(busy), 32'd1);
            check("single_ready_low", 32'(req_ready), 32'd0);
        end
        step();
        check("single_busy_end", 32'(busy), 32'd0);
        check("single_digits_kept", 32'(digits()), 32'h1234);

        // ---------------- 3. round-robin fairness ----------------
        do_reset();
`ifdef SEG_PRIO0_EN
        fair_valid = 4'b1110;
        exp_order  = '{1, 2, 3, 1, 2};
`else
        fair_valid = 4'b1111;
        exp_order  = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            v = 16'((i + 1) * 16'h1111);
            set_val(i, v);
        end
        req_valid = fair_valid;
        last_cyc  = 0;
        for (int g = 0; g < 5; g++) begin
            got = 1'b0;
            for (int t = 0; t < 30 && !got; t++) begin
                step();
                if (req_ready != 4'b0) got = 1'b1;
            end
            check("fair_grant_seen", 32'(got), 32'd1);
            if (got) begin
                $display("grant: owner=%0d value=%h cycle=%0d", owner, digits(), cyc);
                check("fair_owner", 32'(owner), 32'(exp_order[g]));
                check("fair_ready", 32'(req_ready), 32'(1 << exp_order[g]));
                check("fair_digits", 32'(digits()), 32'((exp_order[g] + 1) * 32'h1111));
                if (g > 0) check("fair_spacing", 32'(cyc - last_cyc), 32'd9);
                last_cyc = cyc;
            end
        end
        req_valid = '0;

        // ---------------- 4. withdrawal ----------------
        do_reset();
        set_val(0, 16'h0F0F);
        set_val(1, 16'h7777);
        req_valid = 4'b0001;
        step();
        check("wd_grant0", 32'(req_ready), 32'b0001);
        req_valid = '0;
        for (int t = 2; t <= 15; t++) begin
            req_valid = (t >= 2 && t <= 7) ? 4'b0010 : 4'b0000;
            step();
            check("wd_ready1_low", 32'(req_ready[1]), 32'd0);
        end
        check("wd_owner", 32'(owner), 32'd0);
        check("wd_digits", 32'(digits()), 32'h0F0F);
        $display("withdraw: owner=%0d value=%h", owner, digits());

        // ---------------- 5. mid-hold reset ----------------
        do_reset();
        set_val(3, 16'hCAFE);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();
        step();
        step();
        check("mh_busy_before", 32'(busy), 32'd1);
        check("mh_owner_before", 32'(owner), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mh_digits", 32'(digits()), 32'h0);
        check("mh_owner", 32'(owner), 32'd0);
        check("mh_busy", 32'(busy), 32'd0);
        check("mh_tick", 32'(scan_tick), 32'd0);
        check("mh_sel", 32'(digit_sel), 32'd0);
        step();
        rst_n = 1'b1;
        set_val(1, 16'h5A5A);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        $display("grant: owner=%0d value=%h after reset", owner, digits());
        check("mh_regrant_ready", 32'(req_ready), 32'b0010);
        check("mh_regrant_owner", 32'(owner), 32'd1);
        check("mh_regrant_digits", 32'(digits()), 32'h5A5A);
        rst_n = 1'b0;
        #1;
        check("mh_pulse_cut", 32'(req_ready), 32'd0);

        // ---------------- 6. requester 0 arriving during HOLD ----------------
        step();
        rst_n = 1'b1;
        set_val(3, 16'h3333);
        set_val(0, 16'hBEEF);
        req_valid = 4'b1000;
        step();
        gcyc = cyc;
        check("p0_owner3", 32'(owner), 32'd3);
        req_valid = '0;
        step();
        step();
        req_valid = 4'b0001;
        step();
`ifdef SEG_PRIO0_EN
        $display("preempt: owner=%0d value=%h ready=%b", owner, digits(), req_ready);
        check("p0_owner", 32'(owner), 32'd0);
        check("p0_ready", 32'(req_ready), 32'b0001);
        check("p0_digits", 32'(digits()), 32'hBEEF);
        req_valid = '0;
        for (int j = 2; j <= 8; j++) begin
            step();
            check("p0_busy_hold", 32'(busy), 32'd1);
        end
        step();
        check("p0_busy_end", 32'(busy), 32'd0);
`else
        check("p0_no_preempt_ready", 32'(req_ready), 32'd0);
        check("p0_no_preempt_owner", 32'(owner), 32'd3);
        got = 1'b0;
        for (int t = 0; t < 30 && !got; t++) begin
            step();
            if (req_ready != 4'b0) got = 1'b1;
        end
        check("p0_grant_seen", 32'(got), 32'd1);
        $display("grant: owner=%0d value=%h cycle=%0d", owner, digits(), cyc);
        check("p0_wait_latency", 32'(cyc - gcyc), 32'd9);
        check("p0_owner", 32'(owner), 32'd0);
        check("p0_digits", 32'(digits()), 32'hBEEF);
        req_valid = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the 4-digit seven-segment display among up to NUM_REQ requesters and sequences its digit scan. Each requester offers a 16-bit packed hex value via valid/ready. The block grants round-robin, holds the winner's value on screen for HOLD_CYCLES, and drives the display driver's four digit nibbles. It also generates the divided scan strobe and digit select that pace the display multiplexing, replacing the free-running per-clock scan.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesters, range 2..8.
- HOLD_CYCLES, default 100_000_000: cycles a granted value stays displayed; must be at least 1.
- SCAN_DIV, default 100_000: clk cycles per scan step; must be at least 1.

Ports:
- clk, in, 1: single clock; all state on rising edge.
- rst_n, in, 1: reset is asynchronous and active-low.
- req_valid, in, NUM_REQ: per-requester offer.
- req_value, in, 16*NUM_REQ: requester i occupies [16i+15:16i]; nibble order [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- req_ready, out, NUM_REQ: one-cycle pulse marking acceptance of requester i's value.
- ones, tens, hundreds, thousands, out, 4 each: registered digits to the display driver.
- owner, out, $clog2(NUM_REQ): index of the requester currently displayed.
- busy, out, 1: high while in HOLD.
- scan_tick, out, 1: one-cycle strobe every SCAN_DIV cycles.
- digit_sel, out, 2: active digit index (0 = ones … 3 = thousands); advances on scan_tick.

## Operation
- Reset values: all digits 0, req_ready 0, owner 0, busy 0, scan_tick 0, digit_sel 0, state IDLE, RR pointer 0, hold and scan counters 0.
- FSM states: IDLE and HOLD.
- IDLE with no valid: stay in IDLE; the display keeps the last value.
- IDLE with any valid: grant the first valid index found searching from ptr upward, modulo NUM_REQ.
- On grant, at the same edge:
  - latch that requester's value into the digits;
  - owner is set to the granted index;
  - req_ready[i] goes to 1 for exactly one cycle;
  - ptr becomes (i+1) mod NUM_REQ;
  - hold counter clears to 0;
  - state moves to HOLD.
- HOLD: the hold counter increments each cycle. At count HOLD_CYCLES-1, go to IDLE. req_valid is ignored in HOLD except under the Configuration feature.
- Re-arbitration always costs one IDLE cycle. The display therefore changes at most once per HOLD_CYCLES+1 cycles.
- Handshake:
  - A requester holds valid and value stable until it sees ready.
  - Dropping valid before grant withdraws the request, with no side effects.
  - A requester that keeps valid high after ready is treated as a new offer.
- Round-robin fairness: with all requesters valid continuously, the grant order is 0,1,…,NUM_REQ-1,0.
- A single persistent requester is re-granted every HOLD_CYCLES+1 cycles.
- Scan divider: free-running and independent of the FSM. Counter runs 0..SCAN_DIV-1; scan_tick=1 when the counter equals SCAN_DIV-1. digit_sel increments mod 4 on the edge following the tick cycle. With SCAN_DIV=1, scan_tick is constantly 1.
- Reset asserted mid-HOLD or mid-pulse: all registers return to reset values immediately, asynchronously. A req_ready pulse in flight is cut.

## Timing
- Grant latency: valid sampled in IDLE cycle N → digits, owner, req_ready, busy all valid in cycle N+1.
- HOLD occupies cycles N+1..N+HOLD_CYCLES. IDLE is at N+HOLD_CYCLES+1; the earliest next grant is visible at N+HOLD_CYCLES+2.
- All outputs are registered; no combinational path from req_* to any output.
- digit_sel lags scan_tick by one cycle.

## Configuration
- SEG_PRIO0_EN defined: requester 0 preempts.
  - In HOLD, if req_valid[0]=1 and owner≠0, the next edge latches requester 0's value, pulses req_ready[0], sets owner=0, and clears the hold counter (stays in HOLD).
  - ptr becomes 1.
  - Requester 0 never preempts itself.
- SEG_PRIO0_EN undefined: requester 0 is ordinary round-robin; req_valid is fully ignored in HOLD.

## Structure
- Package seg_pkg:
  - state enum (IDLE, HOLD);
  - DIGIT_W=4;
  - NUM_DIGITS=4;
  - digit-slice localparams for the packed value.
- Sub-module seg_scan_div, parameter SCAN_DIV: scan counter, scan_tick and digit_sel.
- The arbiter FSM, RR pointer and hold counter live in the top.

## Test plan
All scenarios use NUM_REQ=4, HOLD_CYCLES=8, SCAN_DIV=4.
1. Reset: release rst_n → digits 0, owner 0, busy 0; scan_tick pulses at cycles 3, 7, 11…; digit_sel steps 0→1→2→3→0.
2. Single grant: req_valid=4'b0100, value 0x1234 in cycle N → req_ready=4'b0100 for cycle N+1 only; thousands=1, hundreds=2, tens=3, ones=4; owner=2; busy high for 8 cycles.
3. Fairness: all four valid continuously → grants 0,1,2,3,0, spaced 9 cycles apart.
4. Withdrawal: req 1 valid only during HOLD of req 0 → req 1 is never granted, and req_ready[1] stays 0.
5. Mid-hold reset: assert rst_n low in the 4th HOLD cycle → all outputs at reset values within the same cycle; a fresh grant is possible after release.
6. With SEG_PRIO0_EN: owner=3 in HOLD, raise req_valid[0] with value 0xBEEF → next cycle owner=0, digits B,E,E,F, req_ready[0] pulse, HOLD lasts a full 8 cycles from there. Without the macro → req 0 waits for IDLE.
